// File: rtl/display_7seg_scan_pkg.sv
`default_nettype none
// display_7seg_scan_pkg: shared active-low 7-segment patterns, bit order {g,f,e,d,c,b,a}.
package display_7seg_scan_pkg;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_BLANK = 7'h7F;
  localparam seg_t SEG_DASH  = 7'h3F;

  // Element i is the pattern for decimal digit i.
  localparam logic [9:0][6:0] SEG_DIGITS = {
    7'h10, 7'h00, 7'h78, 7'h02, 7'h12,
    7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

endpackage
`default_nettype wire

// File: rtl/display_7seg_scan_bcd_to_7seg.sv
`default_nettype none
// bcd_to_7seg: combinational BCD to active-low 7-segment decode; codes 10..15 show a dash.
module bcd_to_7seg
  import display_7seg_scan_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_DASH;
    if (bcd <= 4'd9) begin
      seg = SEG_DIGITS[bcd];
    end
  end

endmodule
`default_nettype wire

// File: rtl/display_7seg_scan.sv
`default_nettype none
// display_7seg_scan: time-multiplexed N-digit 7-segment driver with per-frame snapshot,
// leading-zero blanking and an anode ghost guard on every digit change.
module display_7seg_scan
  import display_7seg_scan_pkg::*;
#(
  parameter int N        = 3,
  parameter int PRESCALE = 50000
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N*4-1:0] bcd_in,
  input  logic           blank_lz,
  input  logic [N-1:0]   dp_mask,
  output logic [6:0]     seg,
  output logic           dp,
  output logic [N-1:0]   an,
  output logic           frame_done
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int PW = $clog2(PRESCALE);
  localparam logic [PW-1:0] P_LAST   = PW'(PRESCALE - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(N - 1);

  logic [PW-1:0]  p;
  logic [IW-1:0]  idx;
  logic [IW-1:0]  idx_next;
  logic [N*4-1:0] snap;
  logic [N*4-1:0] src;
  logic           tick;
  logic           tick_d;
  logic           wrap;
  logic [3:0]     digit;
  logic           all_zero;
  logic           blank;
  logic [6:0]     seg_dec;
  logic [N-1:0]   an_on;

  assign tick     = (p == P_LAST);
  assign wrap     = (idx == IDX_LAST);
  assign idx_next = wrap ? '0 : idx + 1'b1;
  // Digit 0 of a new frame is latched in the same edge as the snapshot, so read it live.
  assign src      = wrap ? bcd_in : snap;

  always_comb begin
    digit    = 4'd0;
    blank    = 1'b0;
    all_zero = 1'b1;
    for (int i = N - 1; i >= 0; i--) begin
      all_zero = all_zero && (snap[4*i +: 4] == 4'd0);
      if (int'(idx_next) == i) begin
        digit = src[4*i +: 4];
        blank = blank_lz && all_zero && (i != 0);
      end
    end
  end

  always_comb begin
    an_on = '1;
    for (int i = 0; i < N; i++) begin
      if (int'(idx) == i) begin
        an_on[i] = 1'b0;
      end
    end
  end

  bcd_to_7seg u_dec (
    .bcd (digit),
    .seg (seg_dec)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p          <= '0;
      idx        <= IDX_LAST;
      snap       <= '0;
      tick_d     <= 1'b0;
      an         <= '1;
      seg        <= SEG_BLANK;
      dp         <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      tick_d     <= tick;
      frame_done <= 1'b0;
      if (tick) begin
        p   <= '0;
        idx <= idx_next;
        an  <= '1;
        seg <= blank ? SEG_BLANK : seg_dec;
        dp  <= ~dp_mask[idx_next];
        if (wrap) begin
          snap       <= bcd_in;
          frame_done <= 1'b1;
        end
      end else begin
        p <= p + 1'b1;
        // Anode comes on one cycle after the segments settle.
        if (tick_d) begin
          an <= an_on;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_display_7seg_scan.sv
`default_nettype none
// tb_display_7seg_scan: directed stimulus with an edge-count model and literal spot checks.
module tb_display_7seg_scan;

  localparam int N = 3;
  localparam int P = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [11:0]   bcd_in = 12'h123;
  logic          blank_lz = 1'b0;
  logic [2:0]    dp_mask = 3'b000;
  logic [6:0]    seg;
  logic          dp;
  logic [2:0]    an;
  logic          frame_done;

  int checks = 0;
  int errors = 0;

  display_7seg_scan #(.N(N), .PRESCALE(P)) dut (
    .clk        (clk),
    .rst        (rst),
    .bcd_in     (bcd_in),
    .blank_lz   (blank_lz),
    .dp_mask    (dp_mask),
    .seg        (seg),
    .dp         (dp),
    .an         (an),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  logic [6:0] seg_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                               7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  function automatic logic [6:0] model_seg(input logic [11:0] s, input int i, input logic blz);
    logic [3:0] d;
    d = s[4*i +: 4];
    if (blz && i != 0 && (s >> (4*i)) == 12'h000) return 7'h7F;
    if (d > 4'd9) return 7'h3F;
    return seg_tab[d];
  endfunction

  // Model: t counts rising edges since reset release; slot k starts at edge k*P.
  int         t = 0;
  logic [11:0] msnap = '0;
  logic [6:0] m_seg = 7'h7F;
  logic       m_dp = 1'b1;

  initial forever begin
    @(posedge clk);
    if (rst) begin
      t = 0;
    end else begin
      t++;
      if (t % P == 0) begin
        int mi;
        mi = ((t / P) - 1) % N;
        if (mi == 0) msnap = bcd_in;
        m_seg = model_seg(msnap, mi, blank_lz);
        m_dp  = !dp_mask[mi];
      end
    end
  end

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s t=%0d actual=%h expected=%h", name, t, got, exp);
    end
  endtask

  // Per-cycle comparison against the model.
  initial forever begin
    logic [2:0] e_an;
    logic [6:0] e_seg;
    logic       e_dp, e_fd;
    int         r, mi;
    @(posedge clk);
    #2;
    if (rst || t < P) begin
      e_an = 3'b111; e_seg = 7'h7F; e_dp = 1'b1; e_fd = 1'b0;
    end else begin
      r    = t % P;
      mi   = ((t / P) - 1) % N;
      e_an = (r == 0) ? 3'b111 : ~(3'b001 << mi);
      e_fd = (r == 0) && (mi == 0);
      e_seg = m_seg;
      e_dp  = m_dp;
    end
    chk("cyc_an", {5'b0, an}, {5'b0, e_an});
    chk("cyc_seg", {1'b0, seg}, {1'b0, e_seg});
    chk("cyc_dp", {7'b0, dp}, {7'b0, e_dp});
    chk("cyc_frame_done", {7'b0, frame_done}, {7'b0, e_fd});
  end

  task automatic step_to(input int target);
    for (int g = 0; g < 2000 && t < target; g++) begin
      @(posedge clk);
      #2;
    end
    chk("step_reach", 8'(t == target), 8'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog t=%0d actual=timeout expected=finish", t);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_an", {5'b0, an}, 8'h07);
    chk("rst_seg", {1'b0, seg}, 8'h7F);
    chk("rst_dp", {7'b0, dp}, 8'h01);
    chk("rst_fd", {7'b0, frame_done}, 8'h00);
    rst = 1'b0;

    // Frame 0: 123
    step_to(3);  chk("f0_no_fd_early", {7'b0, frame_done}, 8'h00);
    step_to(4);  chk("f0_fd", {7'b0, frame_done}, 8'h01);
                 chk("f0_an_guard", {5'b0, an}, 8'h07);
                 chk("f0_d0_seg", {1'b0, seg}, 8'h30);
    step_to(5);  chk("f0_d0_an", {5'b0, an}, 8'h06);
                 chk("f0_fd_one", {7'b0, frame_done}, 8'h00);
    step_to(7);  chk("f0_d0_an_hold", {5'b0, an}, 8'h06);
    step_to(8);  chk("f0_d1_guard", {5'b0, an}, 8'h07);
                 chk("f0_d1_seg", {1'b0, seg}, 8'h24);
    step_to(9);  chk("f0_d1_an", {5'b0, an}, 8'h05);
    step_to(13); chk("f0_d2_seg", {1'b0, seg}, 8'h79);
                 chk("f0_d2_an", {5'b0, an}, 8'h03);
    @(negedge clk); bcd_in = 12'h007; blank_lz = 1'b1;

    // Frame 1: 007 blanked
    step_to(16); chk("f1_fd", {7'b0, frame_done}, 8'h01);
    step_to(17); chk("f1_d0", {1'b0, seg}, 8'h78);
    step_to(21); chk("f1_d1_blank", {1'b0, seg}, 8'h7F);
    step_to(25); chk("f1_d2_blank", {1'b0, seg}, 8'h7F);
    @(negedge clk); blank_lz = 1'b0;

    // Frame 2: 007 unblanked
    step_to(29); chk("f2_d0", {1'b0, seg}, 8'h78);
    step_to(33); chk("f2_d1", {1'b0, seg}, 8'h40);
    step_to(37); chk("f2_d2", {1'b0, seg}, 8'h40);
    @(negedge clk); bcd_in = 12'h000; blank_lz = 1'b1;

    // Frame 3: 000 blanked, digit 0 kept
    step_to(41); chk("f3_d0", {1'b0, seg}, 8'h40);
    step_to(45); chk("f3_d1", {1'b0, seg}, 8'h7F);
    step_to(49); chk("f3_d2", {1'b0, seg}, 8'h7F);
    @(negedge clk); bcd_in = 12'h111; blank_lz = 1'b0;

    // Frame 4: 111, changed to 999 mid-frame
    step_to(53); chk("f4_d0", {1'b0, seg}, 8'h79);
    step_to(57); chk("f4_d1", {1'b0, seg}, 8'h79);
    @(negedge clk); bcd_in = 12'h999;
    step_to(61); chk("f4_d2_no_tear", {1'b0, seg}, 8'h79);
    step_to(65); chk("f5_d0", {1'b0, seg}, 8'h10);
    step_to(69); chk("f5_d1", {1'b0, seg}, 8'h10);
    step_to(73); chk("f5_d2", {1'b0, seg}, 8'h10);
    @(negedge clk); bcd_in = 12'h0C5; dp_mask = 3'b010;

    // Frame 6: dash and decimal point
    step_to(77); chk("f6_d0", {1'b0, seg}, 8'h12);
                 chk("f6_d0_dp", {7'b0, dp}, 8'h01);
    step_to(81); chk("f6_d1_dash", {1'b0, seg}, 8'h3F);
                 chk("f6_d1_dp", {7'b0, dp}, 8'h00);
    step_to(85); chk("f6_d2", {1'b0, seg}, 8'h40);
                 chk("f6_d2_dp", {7'b0, dp}, 8'h01);

    // Reset pulsed in the digit-1 slot of frame 7
    step_to(93); chk("f7_d1_an", {5'b0, an}, 8'h05);
    @(negedge clk); rst = 1'b1;
    #1;
    chk("mid_rst_an", {5'b0, an}, 8'h07);
    chk("mid_rst_seg", {1'b0, seg}, 8'h7F);
    chk("mid_rst_dp", {7'b0, dp}, 8'h01);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    step_to(3);  chk("post_rst_no_fd", {7'b0, frame_done}, 8'h00);
    step_to(4);  chk("post_rst_fd", {7'b0, frame_done}, 8'h01);
                 chk("post_rst_d0", {1'b0, seg}, 8'h12);
    step_to(30);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
